// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the ALU with a 2-entry skid buffer (valid/ready).
// Optional sticky overflow flag is enabled by defining ALU_STICKY_OVF_EN.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_sum_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             clr_sticky,
  output logic             ovf_sticky
`endif
);

  // State bits are {out_valid, skid_valid}; (0,1) is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } buf_state_t;

  function automatic logic calc_ovf(input logic [2:0] op, input logic a_msb,
                                    input logic b_msb, input logic sum_msb);
    logic beff;
    beff = b_msb ^ op[2];
    return (op[1:0] == 2'b10) & (a_msb == beff) & (sum_msb != a_msb);
  endfunction

  buf_state_t       state_r, state_s;
  logic [WIDTH-1:0] out_result_r, skid_result_r;
  logic             out_zero_r, out_ovf_r, skid_zero_r, skid_ovf_r;
  logic             in_ready_r;
  logic             in_fire_s, out_fire_s;
  logic             load_out_in_s, load_out_skid_s, load_skid_s;
  logic             in_zero_s, in_ovf_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = state_r[1] & out_ready;
  assign in_zero_s  = ~|in_result;
  assign in_ovf_s   = calc_ovf(in_op, in_a_msb, in_b_msb, in_sum_msb);

  // Next-state and datapath load selection for the skid buffer.
  always_comb begin
    state_s         = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          load_out_in_s = 1'b1;
          state_s       = ONE;
        end else begin
          state_s = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_ready) begin
          load_out_in_s = 1'b1;
          state_s       = ONE;
        end else if (in_fire_s) begin
          load_skid_s = 1'b1;
          state_s     = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = ONE;
        end
      end
      FULL: begin
        if (out_ready) begin
          load_out_skid_s = 1'b1;
          state_s         = ONE;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
  end

  // State register; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= ~state_s[0];
    end
  end

  // Output register: reloads from the input or from the skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result_r <= {WIDTH{1'b0}};
      out_zero_r   <= 1'b0;
      out_ovf_r    <= 1'b0;
    end else if (load_out_in_s) begin
      out_result_r <= in_result;
      out_zero_r   <= in_zero_s;
      out_ovf_r    <= in_ovf_s;
    end else if (load_out_skid_s) begin
      out_result_r <= skid_result_r;
      out_zero_r   <= skid_zero_r;
      out_ovf_r    <= skid_ovf_r;
    end
  end

  // Skid entry capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_result_r <= {WIDTH{1'b0}};
      skid_zero_r   <= 1'b0;
      skid_ovf_r    <= 1'b0;
    end else if (load_skid_s) begin
      skid_result_r <= in_result;
      skid_zero_r   <= in_zero_s;
      skid_ovf_r    <= in_ovf_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = state_r[1];
  assign out_result = out_result_r;
  assign out_zero   = out_zero_r;
  assign out_ovf    = out_ovf_r;

`ifdef ALU_STICKY_OVF_EN
  logic ovf_sticky_r;

  // Sticky overflow: set on an overflowing output transfer, which beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky_r <= 1'b0;
    end else if (out_fire_s && out_ovf_r) begin
      ovf_sticky_r <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky_r <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_sticky_r;
`else
  logic unused_fire_s;
  assign unused_fire_s = out_fire_s;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vectors, backpressure, reset, sticky flag.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [2:0]  in_op;
  logic        in_a_msb, in_b_msb, in_sum_msb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_ovf;
`ifdef ALU_STICKY_OVF_EN
  logic        clr_sticky;
  logic        ovf_sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
    .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_sum_msb(in_sum_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf)
`ifdef ALU_STICKY_OVF_EN
    , .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] result;
    logic        a_msb;
    logic        b_msb;
    logic        sum_msb;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bundle(input logic [2:0] op, input logic [31:0] res,
                              input logic a, input logic b, input logic s);
    in_op = op; in_result = res; in_a_msb = a; in_b_msb = b; in_sum_msb = s;
  endtask

  // One cycle of the backpressure stream; called at a negedge, returns at the next negedge.
  int send_idx, recv_cnt, gap_cnt;
  task automatic stream_cycle();
    logic rdy, ov;
    logic [31:0] ores;
    in_valid = (send_idx <= 5);
    drive_bundle(3'b000, send_idx[31:0], 1'b0, 1'b0, 1'b0);
    rdy  = in_ready;
    ov   = out_valid;
    ores = out_result;
    if (recv_cnt > 0 && recv_cnt < 5 && !ov) gap_cnt++;
    @(posedge clk);
    if (in_valid && rdy) send_idx++;
    if (ov && out_ready) begin
      recv_cnt++;
      check($sformatf("order%0d", recv_cnt), {32'd0, ores}, recv_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{3'b010, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // add ovf
    vecs[1] = '{3'b110, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // sub zero
    vecs[2] = '{3'b000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // and, sum_msb=1
    vecs[3] = '{3'b000, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // and, sum_msb=0
    vecs[4] = '{3'b111, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // slt
    vecs[5] = '{3'b110, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // sub pos-neg ovf
    vecs[6] = '{3'b110, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // sub neg-pos ovf
    vecs[7] = '{3'b010, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // add mixed signs
    vecs[8] = '{3'b001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}; // or
    vecs[9] = '{3'b010, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // add neg ovf

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_bundle(3'b000, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);

    // Single-bundle flag vectors, each drained before the next.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      drive_bundle(vecs[i].op, vecs[i].result, vecs[i].a_msb, vecs[i].b_msb, vecs[i].sum_msb);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), out_valid, 1'b1);
      check($sformatf("v%0d_result", i), out_result, vecs[i].result);
      check($sformatf("v%0d_zero", i), out_zero, vecs[i].exp_zero);
      check($sformatf("v%0d_ovf", i), out_ovf, vecs[i].exp_ovf);
      @(posedge clk);
      @(negedge clk);
    end
    check("drained_valid", out_valid, 1'b0);

    // out_ready with nothing buffered has no effect.
    repeat (3) @(negedge clk);
    check("idle_valid", out_valid, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);

    // Backpressure: only two of five bundles are taken while out_ready is low.
    out_ready = 1'b0; send_idx = 1; recv_cnt = 0; gap_cnt = 0;
    repeat (4) stream_cycle();
    check("bp_accepted", send_idx, 3);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_hold", out_result, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && recv_cnt < 5; c++) stream_cycle();
    check("bp_recv_count", recv_cnt, 5);
    check("bp_no_gaps", gap_cnt, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_end_valid", out_valid, 1'b0);

    // Reset while FULL discards both entries.
    out_ready = 1'b0; in_valid = 1'b1;
    drive_bundle(3'b000, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    drive_bundle(3'b000, 32'h0000_00BB, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("rstfull_valid", out_valid, 1'b0);
    check("rstfull_in_ready", in_ready, 1'b1);
    check("rstfull_result", out_result, 32'd0);
    out_ready = 1'b1;
    begin
      int stale;
      stale = 0;
      repeat (4) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      check("rstfull_no_stale", stale, 0);
    end

`ifdef ALU_STICKY_OVF_EN
    check("sticky_after_rst", ovf_sticky, 1'b0);
    // Non-overflow transfer leaves the sticky bit clear.
    in_valid = 1'b1;
    drive_bundle(3'b010, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("sticky_no_ovf", ovf_sticky, 1'b0);
    // Overflow transfer sets it, and it persists.
    in_valid = 1'b1;
    drive_bundle(3'b010, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("sticky_set", ovf_sticky, 1'b1);
    repeat (3) @(negedge clk);
    check("sticky_persist", ovf_sticky, 1'b1);
    // Clear pulse with no overflow.
    clr_sticky = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_sticky = 1'b0;
    check("sticky_clr", ovf_sticky, 1'b0);
    // Clear coincident with an overflowing output transfer: set wins.
    in_valid = 1'b1;
    drive_bundle(3'b110, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    @(posedge clk); @(negedge clk);
    clr_sticky = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
